stopwatch_seg_display: RTL and testbench

- Downstream consumer of the stopwatch time word `disp_time` = {h[4:0], m[5:0], s[5:0], ms[9:0]}, 27 bits.
- Once per display frame, snapshots the word, saturates each field, and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives an 8-digit multiplexed common-anode 7-segment display in HH.MM.SS.CC format; CC is hundredths (ms hundreds and tens digits).

---
 rtl/stopwatch_seg_display.sv | 183 ++++++++++++++++++
 tb/tb_stopwatch_seg_display.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_seg_display.sv
// Stopwatch time-word to 8-digit multiplexed 7-segment display (HH.MM.SS.CC) with double-dabble BCD conversion.
// Optional lap/hold freeze enabled by defining STOPWATCH_SEG_LAP_EN.
module stopwatch_seg_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [26:0] disp_time,
  input  logic        blank_lz,
`ifdef STOPWATCH_SEG_LAP_EN
  input  logic        lap,
`endif
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int NUM_DIGITS = 8;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [9:0] sat(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // One double-dabble step on {bcd[11:0], bin[9:0]}: add-3 to nibbles >= 5, then shift left.
  function automatic logic [21:0] dd_step(input logic [21:0] v);
    logic [21:0] t;
    t = v;
    for (int k = 0; k < 3; k++) begin
      t[10+4*k +: 4] = (t[10+4*k +: 4] >= 4'd5) ? (t[10+4*k +: 4] + 4'd3) : t[10+4*k +: 4];
    end
    t = t << 1;
    return t;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0] pre_r;
  logic [2:0]    idx_r;
  state_t        state_r, state_s;
  logic [3:0]    cnt_r;
  logic [21:0]   acc_r   [4];
  logic [3:0]    digit_r [NUM_DIGITS];
  logic          wrap_s, snap_s;
  logic [6:0]    seg_s;
  logic          dp_s;

  assign wrap_s = (pre_r == PRE_LAST) && (idx_r == 3'd7);

`ifdef STOPWATCH_SEG_LAP_EN
  logic hold_r;
  logic hold_next_s;

  assign hold_next_s = hold_r ^ lap;
  // A lap pulse on the wrap edge already governs that edge's snapshot.
  assign snap_s = wrap_s && !hold_next_s;

  // Lap hold flag, toggled by each lap pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_r <= 1'b0;
    end else begin
      hold_r <= hold_next_s;
    end
  end
`else
  assign snap_s = wrap_s;
`endif

  // Converter next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (snap_s) state_s = CONV;
        else        state_s = IDLE;
      end
      CONV: begin
        if (cnt_r == 4'd9) state_s = COMMIT;
        else               state_s = CONV;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Segment/decimal-point selection for the digit being lit.
  always_comb begin
    seg_s = seg_code(digit_r[idx_r]);
    if (blank_lz && (idx_r == 3'd7) && (digit_r[7] == 4'd0)) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = seg_code(digit_r[idx_r]);
    end
    dp_s = !((idx_r == 3'd2) || (idx_r == 3'd4) || (idx_r == 3'd6));
  end

  // Scan prescaler, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_r <= '0;
      idx_r <= 3'd0;
      an    <= 8'hFF;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      if (pre_r == PRE_LAST) begin
        pre_r <= '0;
        idx_r <= idx_r + 3'd1;
      end else begin
        pre_r <= pre_r + PW'(1);
      end
      an  <= ~(8'd1 << idx_r);
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

  // Snapshot, 10-step parallel BCD conversion and atomic digit commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      cnt_r   <= 4'd0;
      for (int i = 0; i < 4; i++) acc_r[i] <= 22'd0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_r[i] <= 4'd0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (snap_s) begin
            cnt_r    <= 4'd0;
            acc_r[0] <= {12'd0, sat(disp_time[9:0], 10'd999)};
            acc_r[1] <= {12'd0, sat({4'd0, disp_time[15:10]}, 10'd59)};
            acc_r[2] <= {12'd0, sat({4'd0, disp_time[21:16]}, 10'd59)};
            acc_r[3] <= {12'd0, sat({5'd0, disp_time[26:22]}, 10'd23)};
          end
        end
        CONV: begin
          cnt_r <= cnt_r + 4'd1;
          for (int i = 0; i < 4; i++) acc_r[i] <= dd_step(acc_r[i]);
        end
        COMMIT: begin
          digit_r[7] <= acc_r[3][17:14];
          digit_r[6] <= acc_r[3][13:10];
          digit_r[5] <= acc_r[2][17:14];
          digit_r[4] <= acc_r[2][13:10];
          digit_r[3] <= acc_r[1][17:14];
          digit_r[2] <= acc_r[1][13:10];
          digit_r[1] <= acc_r[0][21:18];
          digit_r[0] <= acc_r[0][17:14];
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_seg_display.sv
// Self-checking bench for stopwatch_seg_display (SCAN_DIV=2); the lap section is built only with STOPWATCH_SEG_LAP_EN.
module tb_stopwatch_seg_display;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [26:0] disp_time = 27'd0;
  logic        blank_lz = 1'b0;
`ifdef STOPWATCH_SEG_LAP_EN
  logic        lap = 1'b0;
`endif
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int vectors = 0;
  int errors  = 0;
  int exp_d [8];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  stopwatch_seg_display #(.SCAN_DIV(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .disp_time(disp_time),
    .blank_lz(blank_lz),
`ifdef STOPWATCH_SEG_LAP_EN
    .lap(lap),
`endif
    .an(an),
    .seg(seg),
    .dp(dp),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] mk(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  // Reference: clamp each field, then split into decimal digits by plain arithmetic.
  task automatic model_load(input logic [26:0] t);
    int h, m, s, ms;
    h  = int'(t[26:22]); if (h > 23)   h = 23;
    m  = int'(t[21:16]); if (m > 59)   m = 59;
    s  = int'(t[15:10]); if (s > 59)   s = 59;
    ms = int'(t[9:0]);   if (ms > 999) ms = 999;
    exp_d[7] = h / 10;  exp_d[6] = h % 10;
    exp_d[5] = m / 10;  exp_d[4] = m % 10;
    exp_d[3] = s / 10;  exp_d[2] = s % 10;
    exp_d[1] = ms / 100; exp_d[0] = (ms / 10) % 10;
  endtask

  task automatic check_frame(input string tag);
    int k;
    logic [6:0] es;
    repeat (16) begin
      @(negedge clk);
      k = -1;
      for (int i = 0; i < 8; i++) if (an === ~(8'd1 << i)) k = i;
      chk({tag, "_an_onehot"}, 32'(k >= 0), 32'd1);
      if (k >= 0) begin
        es = (blank_lz && k == 7 && exp_d[7] == 0) ? 7'h7F : seg_tab[exp_d[k]];
        chk({tag, "_seg"}, 32'(seg), 32'(es));
        chk({tag, "_dp"}, 32'(dp), 32'((k == 2 || k == 4 || k == 6) ? 0 : 1));
      end
    end
  endtask

  // Waits for a fresh conversion, checks busy width, and leaves time at the first edge showing new digits.
  task automatic wait_conv(input string tag);
    int t = 0;
    int len = 0;
    while (busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    while (busy !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    while (busy === 1'b1 && t < 200) begin len++; @(negedge clk); t++; end
    if (t >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
    chk({tag, "_busy_len"}, 32'(len), 32'd11);
    @(posedge clk);
  endtask

  initial begin
    logic [26:0] t;
    int guard;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    t = mk(12, 34, 56, 789);
    disp_time = t;
    @(negedge clk);
    chk("first_an", 32'(an), 32'hFE);
    chk("first_seg", 32'(seg), 32'h40);

    // Nominal conversion
    model_load(t);
    wait_conv("conv");
    check_frame("conv");

    // Saturation of every field
    t = mk(31, 60, 63, 1023);
    disp_time = t;
    model_load(t);
    wait_conv("sat");
    check_frame("sat");

    // Leading-zero blanking on and off
    blank_lz = 1'b1;
    t = mk(5, 7, 9, 450);
    disp_time = t;
    model_load(t);
    wait_conv("lz");
    check_frame("lz_on");
    blank_lz = 1'b0;
    check_frame("lz_off");

    // Randomised time words, often out of range
    repeat (6) begin
      t = 27'($urandom());
      disp_time = t;
      blank_lz = 1'($urandom_range(0, 1));
      model_load(t);
      wait_conv("rnd");
      check_frame("rnd");
    end

    // Reset during the fifth conversion cycle
    blank_lz = 1'b0;
    t = mk(21, 48, 17, 333);
    disp_time = t;
    guard = 0;
    while (busy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    chk("mid_busy_seen", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_an", 32'(an), 32'hFF);
    reset_n = 1'b1;
    model_load(27'd0);
    @(posedge clk);
    check_frame("mid_zero");
    model_load(t);
    wait_conv("mid_reconv");
    check_frame("mid_reconv");

`ifdef STOPWATCH_SEG_LAP_EN
    // Lap freeze and release
    t = mk(0, 0, 1, 0);
    disp_time = t;
    model_load(t);
    wait_conv("lap_pre");
    check_frame("lap_pre");
    @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    disp_time = mk(0, 0, 3, 0);
    repeat (16) begin @(negedge clk); chk("lap_busy", 32'(busy), 32'd0); end
    disp_time = mk(0, 0, 5, 0);
    repeat (32) begin @(negedge clk); chk("lap_busy", 32'(busy), 32'd0); end
    check_frame("lap_frozen");
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    model_load(mk(0, 0, 5, 0));
    wait_conv("lap_post");
    check_frame("lap_post");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
